// File: rtl/sprite_pkg.sv
// Shared constants, state encoding and per-axis motion helpers for the sprite controller.
package sprite_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        FAST
    } motion_state_e;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_POS,
        DIR_NEG
    } axis_dir_e;

    // Opposing buttons cancel, so both-pressed is the same as neither.
    function automatic axis_dir_e axis_dir(input logic pos_btn, input logic neg_btn);
        axis_dir_e dir;
        dir = DIR_NONE;
        if (pos_btn && !neg_btn) begin
            dir = DIR_POS;
        end else if (neg_btn && !pos_btn) begin
            dir = DIR_NEG;
        end
        return dir;
    endfunction

    // 11-bit arithmetic leaves headroom for pos+step; the low edge saturates at zero.
    function automatic logic [9:0] step_axis(input logic [9:0]  pos,
                                             input axis_dir_e   dir,
                                             input logic [10:0] step,
                                             input logic [10:0] max_pos);
        logic [10:0] cur;
        logic [10:0] nxt;
        cur = {1'b0, pos};
        nxt = cur;
        case (dir)
            DIR_POS: begin
                nxt = cur + step;
                if (nxt > max_pos) begin
                    nxt = max_pos;
                end
            end
            DIR_NEG: begin
                nxt = (cur < step) ? 11'd0 : (cur - step);
            end
            default: begin
                nxt = cur;
            end
        endcase
        return nxt[9:0];
    endfunction

endpackage

// File: rtl/button_sync.sv
// Two-flop synchronizer for asynchronous button inputs; resets to released.
module button_sync #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Moves a sprite once per frame from button input, with hold-to-accelerate and screen clamping.
module sprite_motion_ctrl
    import sprite_pkg::*;
#(
    parameter int unsigned STEP        = 4,
    parameter int unsigned FAST_FRAMES = 8,
    parameter int unsigned SPRITE_W    = 32,
    parameter int unsigned SPRITE_H    = 32,
    parameter int unsigned INIT_X      = 304,
    parameter int unsigned INIT_Y      = 400
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic [3:0] btn,
    output logic [9:0] posX,
    output logic [9:0] posY,
    output logic       frame_tick,
    output logic       fast
);

    localparam logic [10:0] X_MAX     = 11'(H_ACTIVE - SPRITE_W);
    localparam logic [10:0] Y_MAX     = 11'(V_ACTIVE - SPRITE_H);
    localparam logic [10:0] STEP_SLOW = 11'(STEP);
    localparam logic [10:0] STEP_FAST = 11'(2 * STEP);
    localparam int unsigned CNT_W     = $clog2(FAST_FRAMES + 1);

    logic [3:0]       bs;
    logic             vsync_q;
    logic             tick_q;
    motion_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       pos_x_q, pos_x_d;
    logic [9:0]       pos_y_q, pos_y_d;
    axis_dir_e        dir_x;
    axis_dir_e        dir_y;
    logic             active;
    logic [10:0]      step;

    button_sync #(
        .WIDTH(4)
    ) u_button_sync (
        .clk(clk),
        .rst(rst),
        .d  (btn),
        .q  (bs)
    );

    // bs = {up, down, left, right}
    assign dir_x  = axis_dir(bs[0], bs[1]);
    assign dir_y  = axis_dir(bs[2], bs[3]);
    assign active = (dir_x != DIR_NONE) || (dir_y != DIR_NONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            vsync_q <= vsync;
            tick_q  <= vsync_q & ~vsync;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        step    = (state_q == FAST) ? STEP_FAST : STEP_SLOW;

        if (tick_q) begin
            // Walls only stop the position; the FSM still sees the press as active.
            pos_x_d = step_axis(pos_x_q, dir_x, step, X_MAX);
            pos_y_d = step_axis(pos_y_q, dir_y, step, Y_MAX);

            case (state_q)
                IDLE: begin
                    if (active) begin
                        state_d = HOLD;
                        cnt_d   = CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (!active) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(FAST_FRAMES - 1)) begin
                        state_d = FAST;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                FAST: begin
                    if (!active) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pos_x_q <= 10'(INIT_X);
            pos_y_q <= 10'(INIT_Y);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
        end
    end

    assign posX       = pos_x_q;
    assign posY       = pos_y_q;
    assign frame_tick = tick_q;
    assign fast       = (state_q == FAST);

endmodule

// File: doc/sprite_motion_ctrl.md
SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

Interface
REQ-001 SHALL have parameter STEP, default 4, base displacement in pixels per frame.
REQ-002 SHALL have parameter FAST_FRAMES, default 8, consecutive held frames before double-speed.
REQ-003 SHALL have parameters SPRITE_W, SPRITE_H, default 32, 32, sprite footprint in pixels.
REQ-004 SHALL have parameters INIT_X, INIT_Y, default 304, 400, reset position (top-left corner).
REQ-005 SHALL have port clk, input, 1, the single clock, pixel clock of the VGA domain.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port vsync, input, 1, active-low vertical sync from VGA timing, synchronous to clk.
REQ-008 SHALL have port btn, input, 4, raw asynchronous buttons {up,down,left,right}, active-high.
REQ-009 SHALL have ports posX, posY, output, 10 each, sprite top-left position for the pixel generator.
REQ-010 SHALL have port frame_tick, output, 1, one-cycle pulse on vsync falling edge.
REQ-011 SHALL have port fast, output, 1, high while in state FAST.

Function
REQ-012 SHALL pass btn through a 2-flop synchronizer; only synchronized values (bs) are used downstream.
REQ-013 SHALL register vsync each cycle; frame_tick SHALL be high exactly one cycle, the cycle after registered vsync=1 and vsync=0.
REQ-014 SHALL update posX/posY, state and hold counter only on clock edges where frame_tick=1; otherwise hold.
REQ-015 SHALL define X direction: right-only -> +step, left-only -> -step, both or neither -> 0; Y likewise (down +, up -).
REQ-016 SHALL use step = STEP in IDLE and HOLD, 2*STEP in FAST, selected by the state value present at the updating edge.
REQ-017 SHALL compute sums in 11 bits and clamp: X to [0, 640-SPRITE_W], Y to [0, 480-SPRITE_H]; subtraction below 0 saturates to 0.
REQ-018 SHALL implement FSM IDLE/HOLD/FAST; "active" = any axis with nonzero direction per REQ-015.
REQ-019 IDLE: active -> HOLD with hold_cnt=1; else stay.
REQ-020 HOLD: not active -> IDLE, hold_cnt=0; active and hold_cnt=FAST_FRAMES-1 -> FAST; else hold_cnt+1.
REQ-021 FAST: not active -> IDLE, hold_cnt=0; else stay.
REQ-022 SHALL still advance FSM when motion is blocked by a clamp (pressing into a wall counts as active).
REQ-023 SHALL make new posX/posY visible on outputs the cycle after the frame_tick cycle (one-cycle latency, within vertical blanking).

Reset
REQ-024 On rst: posX=INIT_X, posY=INIT_Y, state=IDLE, hold_cnt=0, frame_tick=0, fast=0, synchronizer and vsync registers=1 for vsync, 0 for btn.
REQ-025 Reset asserted mid-frame SHALL take effect immediately; first post-reset move SHALL occur on the first vsync falling edge seen after release.

Structure
REQ-026 SHALL place H_ACTIVE=640, V_ACTIVE=480 and the state enum (IDLE, HOLD, FAST) in shared package sprite_pkg.
REQ-027 SHALL instantiate sub-module button_sync (parameterized width, 2-flop, async reset to 0) for btn.
REQ-028 SHALL contain no combinational path from btn or vsync to any output.

Verification
REQ-029 Reset then three frames with btn=0001 (right) -> posX 304->308->312->316, posY=400, fast=0.
REQ-030 Hold right for 10 frames from posX=304 -> frames 1-8 add 4, fast=1 after 8th tick, frames 9-10 add 8; posX=352.
REQ-031 posX=606, btn=right, FAST -> posX clamps 608 and stays 608; state stays FAST; fast=1.
REQ-032 posY=2, btn=up -> posY=0, next frame stays 0; btn=1100 (up+down) -> posY unchanged, state IDLE.
REQ-033 btn toggled high for 100 cycles between vsync edges -> no position change; frame_tick exactly one pulse per vsync low.
REQ-034 Assert rst while in FAST with posX=500 -> outputs return to 304/400, fast=0 same cycle, no move until next vsync falling edge.
